// File: rtl/stim_sequencer.sv
// stim_sequencer
//   Paces the taillight stimulus ROM and selects between scripted (ROM) and
//   manual switch stimulus for the next-state logic. Everything runs in the
//   single system clock domain; a tick counter replaces the old divided ROM
//   clock.
//
// Ports
//   clock      system clock
//   reset      asynchronous, active-high reset
//   auto_en    async level: 1 = scripted stimulus, 0 = manual switches
//   run_en     async level: 1 = auto-advance on tick, 0 = paused
//   step_req   async level: rising edge advances one step while paused
//   man_hzrd   async manual hazard switch
//   man_sig    async manual turn-signal switch
//   man_brk    async manual brake switch
//   man_dir    async manual direction (1 = left, 0 = right)
//   rom_q      ROM word {dir, brk, sig, hzrd}, one-cycle read latency
//   rom_addr   registered ROM address (current step index)
//   hzrd_out   registered hazard request
//   brk_out    registered brake request
//   sig_l_out  registered left-signal request (sig & dir)
//   sig_r_out  registered right-signal request (sig & ~dir)
//   auto_act   high whenever the controller is not in MANUAL
//   seq_wrap   one-cycle pulse when rom_addr wraps from the last step to 0
module stim_sequencer #(
  parameter int TICK_DIV  = 10000000,
  parameter int NUM_STEPS = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              auto_en,
  input  logic              run_en,
  input  logic              step_req,
  input  logic              man_hzrd,
  input  logic              man_sig,
  input  logic              man_brk,
  input  logic              man_dir,
  input  logic [3:0]        rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              hzrd_out,
  output logic              brk_out,
  output logic              sig_l_out,
  output logic              sig_r_out,
  output logic              auto_act,
  output logic              seq_wrap
);

  localparam int                CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_STEPS - 1);

  typedef enum logic [2:0] {MANUAL, FETCH, LOAD, RUN, PAUSE} state_t;

  // Synchronizer bit layout: {auto, run, step, dir, brk, sig, hzrd}
  logic [6:0]        sync1_q;
  logic [6:0]        sync2_q;
  logic              step_prev_q;
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        req_q;     // {hzrd, brk, sig_l, sig_r}
  logic              wrap_q;

  logic              auto_s;
  logic              run_s;
  logic              step_s;
  logic              step_edge;
  logic              wrap_d;
  logic [ADDR_W-1:0] addr_adv_d;

  // Word layout {dir, brk, sig, hzrd} is shared by the ROM and the switches.
  function automatic logic [3:0] decode_req(input logic [3:0] w);
    return {w[0], w[2], w[1] & w[3], w[1] & ~w[3]};
  endfunction

  assign auto_s     = sync2_q[6];
  assign run_s      = sync2_q[5];
  assign step_s     = sync2_q[4];
  assign step_edge  = step_s & ~step_prev_q;
  assign wrap_d     = (addr_q == LAST_ADDR);
  assign addr_adv_d = wrap_d ? '0 : addr_q + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      step_prev_q <= 1'b0;
      state_q     <= MANUAL;
      cnt_q       <= '0;
      addr_q      <= '0;
      req_q       <= '0;
      wrap_q      <= 1'b0;
    end else begin
      sync1_q     <= {auto_en, run_en, step_req, man_dir, man_brk, man_sig, man_hzrd};
      sync2_q     <= sync1_q;
      step_prev_q <= step_s;
      wrap_q      <= 1'b0;

      // Checks are ordered so that leaving auto mode beats a run/pause change,
      // which in turn beats a tick expiry or a step edge.
      case (state_q)
        MANUAL: begin
          req_q <= decode_req(sync2_q[3:0]);
          if (auto_s) begin
            addr_q  <= '0;
            state_q <= FETCH;
          end
        end
        // Address is held for one cycle so the synchronous ROM registers it.
        FETCH: state_q <= auto_s ? LOAD : MANUAL;
        LOAD: begin
          if (!auto_s) begin
            state_q <= MANUAL;          // drop the in-flight word
          end else begin
            req_q   <= decode_req(rom_q);
            cnt_q   <= '0;
            state_q <= run_s ? RUN : PAUSE;
          end
        end
        RUN: begin
          if (!auto_s) begin
            state_q <= MANUAL;
          end else if (!run_s) begin
            state_q <= PAUSE;           // counter keeps its value for resume
          end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            addr_q  <= addr_adv_d;
            wrap_q  <= wrap_d;
            state_q <= FETCH;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PAUSE: begin
          if (!auto_s) begin
            state_q <= MANUAL;
          end else if (run_s) begin
            state_q <= RUN;
          end else if (step_edge) begin
            addr_q  <= addr_adv_d;
            wrap_q  <= wrap_d;
            state_q <= FETCH;
          end
        end
        default: state_q <= MANUAL;
      endcase
    end
  end

  assign rom_addr  = addr_q;
  assign hzrd_out  = req_q[3];
  assign brk_out   = req_q[2];
  assign sig_l_out = req_q[1];
  assign sig_r_out = req_q[0];
  assign auto_act  = (state_q != MANUAL);
  assign seq_wrap  = wrap_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: manual-mode vector table, hand-written sequences
// for the scripted corner cases, and a randomized run compared each cycle
// against a behavioural model of the sequencing rules.
module tb_stim_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int NUM_STEPS = 8;
  localparam int ADDR_W    = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic auto_en, run_en, step_req, man_hzrd, man_sig, man_brk, man_dir;
  logic [3:0]        rom_q;
  logic [ADDR_W-1:0] rom_addr;
  logic hzrd_out, brk_out, sig_l_out, sig_r_out, auto_act, seq_wrap;

  // Word layout {dir, brk, sig, hzrd}
  logic [3:0] rom_mem [NUM_STEPS] = '{4'b0001, 4'b1010, 4'b0010, 4'b0100,
                                      4'b1011, 4'b0110, 4'b1101, 4'b0011};

  int tests = 0;
  int fails = 0;

  stim_sequencer #(.TICK_DIV(TICK_DIV), .NUM_STEPS(NUM_STEPS), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .auto_en(auto_en), .run_en(run_en),
    .step_req(step_req), .man_hzrd(man_hzrd), .man_sig(man_sig),
    .man_brk(man_brk), .man_dir(man_dir), .rom_q(rom_q), .rom_addr(rom_addr),
    .hzrd_out(hzrd_out), .brk_out(brk_out), .sig_l_out(sig_l_out),
    .sig_r_out(sig_r_out), .auto_act(auto_act), .seq_wrap(seq_wrap)
  );

  always #5 clock = ~clock;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clock) rom_q <= rom_mem[rom_addr];

  // ---------------- behavioural reference model ----------------
  logic [6:0] m_hist [4];   // pin samples, [0] newest: {auto,run,step,dir,brk,sig,hzrd}
  bit         m_manual, m_running, m_wrap;
  int         m_loadcd;     // 2: waiting for ROM read, 1: word ready, 0: settled
  int         m_cnt, m_addr;
  logic [3:0] m_out;        // {hzrd, brk, sig_l, sig_r}

  function automatic logic [3:0] req_of(input logic [3:0] w);
    return {w[0], w[2], w[1] & w[3], w[1] & ~w[3]};
  endfunction

  function automatic logic [3:0] outs();
    return {hzrd_out, brk_out, sig_l_out, sig_r_out};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
    m_manual = 1; m_running = 0; m_wrap = 0;
    m_loadcd = 0; m_cnt = 0; m_addr = 0; m_out = '0;
  endtask

  task automatic model_advance();
    if (m_addr == NUM_STEPS - 1) begin
      m_addr = 0;
      m_wrap = 1;
    end else begin
      m_addr++;
    end
    m_loadcd = 2;
  endtask

  // Decisions use the pins seen two clocks earlier; the step edge compares
  // that sample against the one before it.
  task automatic model_update();
    logic [6:0] s;
    logic       step_old;
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = {auto_en, run_en, step_req, man_dir, man_brk, man_sig, man_hzrd};
    s        = m_hist[2];
    step_old = m_hist[3][4];
    m_wrap   = 0;
    if (m_manual) begin
      m_out = req_of(s[3:0]);
      if (s[6]) begin
        m_manual = 0; m_addr = 0; m_loadcd = 2;
      end
    end else if (!s[6]) begin
      m_manual = 1;
    end else if (m_loadcd == 2) begin
      m_loadcd = 1;
    end else if (m_loadcd == 1) begin
      m_out = req_of(rom_mem[m_addr]);
      m_cnt = 0; m_loadcd = 0; m_running = s[5];
    end else if (m_running) begin
      if (!s[5]) m_running = 0;
      else if (m_cnt == TICK_DIV - 1) model_advance();
      else m_cnt++;
    end else begin
      if (s[5]) m_running = 1;
      else if (s[4] && !step_old) model_advance();
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_update();
    @(negedge clock);
    check("model", 32'({rom_addr, outs(), auto_act, seq_wrap}),
          32'({3'(m_addr), m_out, !m_manual, m_wrap}));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_addr(input string nm, input logic [2:0] a, input int budget);
    int n = 0;
    while (rom_addr != a && n < budget) begin
      tick();
      n++;
    end
    check(nm, 32'(rom_addr), 32'(a));
  endtask

  task automatic ticks_to_change(output int n);
    logic [2:0] start;
    start = rom_addr;
    n = 0;
    do begin
      tick();
      n++;
    end while (rom_addr == start && n < 50);
  endtask

  typedef struct {
    logic [3:0] man;   // {dir, brk, sig, hzrd}
    logic [3:0] exp;   // {hzrd, brk, sig_l, sig_r}
  } man_vec_t;

  man_vec_t tbl [7];

  initial begin
    int n;
    logic [3:0] prev;

    tbl[0] = '{4'b0001, 4'b1000};
    tbl[1] = '{4'b0010, 4'b0001};
    tbl[2] = '{4'b1010, 4'b0010};
    tbl[3] = '{4'b1100, 4'b0100};
    tbl[4] = '{4'b1111, 4'b1110};
    tbl[5] = '{4'b1000, 4'b0000};
    tbl[6] = '{4'b0110, 4'b0101};

    {auto_en, run_en, step_req, man_dir, man_brk, man_sig, man_hzrd} = '0;
    #1 reset = 1'b1;
    model_reset();
    #1 check("reset_state", 32'({rom_addr, outs(), auto_act, seq_wrap}), 32'd0);
    ticks(2);
    reset = 1'b0;
    ticks(2);

    // Manual table: old value after 2 clocks, new value after the 3rd.
    prev = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      {man_dir, man_brk, man_sig, man_hzrd} = tbl[i].man;
      ticks(2);
      check("manual_latency", 32'(outs()), 32'(prev));
      tick();
      check("manual_vec", 32'(outs()), 32'(tbl[i].exp));
      prev = tbl[i].exp;
    end

    // Scripted run: first load lands on the 5th clock.
    auto_en = 1; run_en = 1;
    ticks(4);
    check("auto_entry_hold", 32'(outs()), 32'b0101);
    tick();
    check("first_load", 32'(outs()), 32'b1000);
    wait_addr("reach_addr1", 3'd1, 20);
    tick();
    check("rom1_hold", 32'(outs()), 32'b1000);
    tick();
    check("rom1_out", 32'(outs()), 32'b0010);
    wait_addr("reach_addr2", 3'd2, 20);
    ticks_to_change(n);
    check("step_period", 32'(n), 32'd6);
    check("addr_after_period", 32'(rom_addr), 32'd3);
    wait_addr("reach_addr7", 3'd7, 40);
    ticks_to_change(n);
    check("wrap_addr", 32'(rom_addr), 32'd0);
    check("wrap_pulse", 32'(seq_wrap), 32'd1);
    tick();
    check("wrap_pulse_end", 32'(seq_wrap), 32'd0);

    // Reset in the middle of a run.
    wait_addr("reach_addr5", 3'd5, 40);
    ticks(2);
    check("pre_reset_out", 32'(outs()), 32'b0101);
    reset = 1'b1;
    model_reset();
    #1 check("async_reset", 32'({rom_addr, outs(), auto_act, seq_wrap}), 32'd0);
    tick();
    reset = 1'b0;
    ticks(2);
    check("post_reset_manual", 32'(auto_act), 32'd0);
    tick();
    check("post_reset_fetch", 32'(auto_act), 32'd1);
    tick();
    check("post_reset_noload", 32'(outs()), 32'b0101);
    tick();
    check("post_reset_load", 32'(outs()), 32'b1000);

    // Pause, then single steps.
    wait_addr("reach_addr2b", 3'd2, 40);
    run_en = 0;
    ticks(20);
    check("pause_hold", 32'(rom_addr), 32'd2);
    step_req = 1;
    ticks(3);
    check("step_advance", 32'(rom_addr), 32'd3);
    tick();
    check("step_out_hold", 32'(outs()), 32'b0001);
    tick();
    check("step_out_new", 32'(outs()), 32'b0100);
    ticks(5);
    step_req = 0;
    ticks(5);
    check("step_once", 32'(rom_addr), 32'd3);
    step_req = 1; tick();
    step_req = 0; tick();
    step_req = 1; tick();
    check("step_again", 32'(rom_addr), 32'd4);
    step_req = 0;
    ticks(10);
    check("step_in_load_dropped", 32'(rom_addr), 32'd4);

    // Abort while the ROM read is in flight.
    step_req = 1; tick();
    step_req = 0; auto_en = 0; tick();
    tick();
    check("abort_fetch_addr", 32'(rom_addr), 32'd5);
    check("abort_fetch_act", 32'(auto_act), 32'd1);
    tick();
    check("abort_act", 32'(auto_act), 32'd0);
    check("abort_noload", 32'(outs()), 32'b1010);
    tick();
    check("abort_manual_out", 32'(outs()), 32'b0101);
    ticks(5);
    check("abort_addr_kept", 32'(rom_addr), 32'd5);

    // run_s falls on the same cycle as tick expiry.
    auto_en = 1; run_en = 1;
    wait_addr("reenter_addr0", 3'd0, 20);
    ticks(3);
    run_en = 0;
    ticks(3);
    check("simul_no_advance", 32'(rom_addr), 32'd0);
    ticks(5);
    check("simul_paused", 32'(rom_addr), 32'd0);
    run_en = 1;
    ticks(3);
    check("resume_wait", 32'(rom_addr), 32'd0);
    tick();
    check("resume_advance", 32'(rom_addr), 32'd1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) auto_en = ~auto_en;
      if ($urandom_range(11) == 0) run_en = ~run_en;
      if ($urandom_range(2) == 0) step_req = ~step_req;
      if ($urandom_range(7) == 0) {man_dir, man_brk, man_sig, man_hzrd} = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
